cordic_vector_iter: RTL and testbench
=====================================

Name: cordic_vector_iter

Overview:
- Parametrised, iterative, handshaked successor to the combinational CORDIC vectoring core.
- Performs one micro-rotation per clock and drives y toward zero.
- Supports circular (magnitude and atan2), linear (y/x) and hyperbolic (atanh, sqrt(x²−y²)) modes.
- Sits between the fixed-point operand source and result consumer; valid/ready on both sides; one operation in flight.

Parameters:
- WIDTH, 32: width of x/y/angle ports, signed two's complement.
- FRAC, 16: fractional bits (Q(WIDTH-FRAC).FRAC).
- ITERATIONS, 16: micro-rotation steps per operation, all modes; 2 ≤ ITERATIONS ≤ FRAC.
- GUARD, 2: extra internal MSBs on the x/y/z datapath.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept (high only in IDLE).
- mode  in  2  00 CIRCULAR, 01 LINEAR, 10 HYPERBOLIC, 11 illegal.
- x  in  WIDTH  signed x operand.
- y  in  WIDTH  signed y operand.
- angle  in  WIDTH  initial z accumulator (normally 0).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- rotated_x  out  WIDTH  final x, saturated.
- rotated_y  out  WIDTH  residual y, saturated.
- final_angle  out  WIDTH  final z, saturated.
- err  out  1  result came from illegal mode.

Behaviour:
- Reset, synchronous and dominant over everything:
  - state = IDLE, in_ready = 1, out_valid = 0, err = 0.
  - All outputs and internal registers = 0.
  - Applies mid-operation: the in-flight op is discarded, with no out_valid pulse.
- States and transitions:
  - IDLE: in_ready = 1. On in_valid && in_ready, latch operands (pre-rotated), step = 0, go to ITER.
  - Illegal mode: from IDLE go directly to DONE with rotated_x = x, rotated_y = y, final_angle = angle, err = 1.
  - ITER: one micro-rotation per cycle. After step ITERATIONS-1 completes, go to DONE.
  - DONE: out_valid = 1, in_ready = 0. On out_ready go to IDLE, out_valid = 0.
- Latency:
  - Accept at edge k gives out_valid high after edge k+ITERATIONS (k+1 for illegal mode).
  - No back-to-back accept on the handshake cycle; throughput is 1 op per ITERATIONS+2 cycles minimum.
- Backpressure:
  - While out_valid && !out_ready, all outputs are held stable and in_valid is ignored.
  - After consumption, outputs hold their last value until the next result; err clears when the next op is accepted.
- Pre-rotation, circular only:
  - If x < 0: x0 = −x, y0 = −y, z0 = angle + PI if y ≥ 0, else angle − PI.
  - PI = round(π·2^FRAC).
  - Linear and hyperbolic: no pre-rotation; x0, y0 and z0 are the raw inputs.
- Direction: d = −1 if sign(x_i) == sign(y_i) (y = 0 counts as positive), else +1.
- Shift index s per step:
  - Circular: s = step.
  - Linear: s = step.
  - Hyperbolic: sequence 1, 2, 3, 4, 4, 5, …, 13, 13, 14, …, truncated to ITERATIONS entries (indices 4, 13, 40 repeated once).
- Update equations (>>> is arithmetic shift on a WIDTH+GUARD datapath):
  - Circular: x' = x − d·(y>>>s); y' = y + d·(x>>>s); z' = z − d·atan(2^-s).
  - Linear: x' = x; y' = y + d·(x>>>s); z' = z − d·2^-s.
  - Hyperbolic: x' = x + d·(y>>>s); y' = y + d·(x>>>s); z' = z − d·atanh(2^-s).
- Constant tables: round(atan(2^-s)·2^FRAC) and round(atanh(2^-s)·2^FRAC), indexed by s, computed at elaboration.
- No gain compensation:
  - Circular: rotated_x ≈ 1.646760·√(x²+y²).
  - Hyperbolic: rotated_x ≈ 0.828159·√(x²−y²).
- Convergence domains: circular any input; linear |y/x| < 2; hyperbolic |y/x| < 0.8; otherwise the result is unspecified but err = 0.
- Output saturation: each output clamps to [−2^(WIDTH-1), 2^(WIDTH-1)−1] when converting from WIDTH+GUARD.

Test Plan:
- FRAC = 16, ITERATIONS = 16, tolerance ±8 LSB unless noted.
- Circular x=0x00030000 (3.0), y=0x00040000 (4.0), angle=0:
  - rotated_x ≈ 539607, final_angle ≈ 60771, rotated_y ≈ 0.
  - out_valid exactly 16 cycles after accept.
- Circular x=−1.0 (0xFFFF0000), y=1.0, angle=0: final_angle ≈ 154415 (3π/4), rotated_x ≈ 152624.
- Linear x=2.0, y=1.0: final_angle ≈ 0x8000, rotated_x = 0x00020000 exactly.
- Hyperbolic x=1.0, y=0.5: final_angle ≈ 35999, rotated_x ≈ 47003 (±16 LSB).
- mode=11, x=5, y=7:
  - out_valid one cycle after accept, err=1, rotated_x=5, rotated_y=7.
  - The next legal op clears err.
- Backpressure and reset:
  - out_ready low 5 cycles: outputs stable, in_ready=0, in_valid pulses ignored.
  - Separately, assert reset at step 5: after the next edge, out_valid=0, in_ready=1, all outputs 0, and no spurious result follows.

Source files
------------

// File: rtl/cordic_vector_iter.sv
// Iterative CORDIC vectoring engine. It performs one micro-rotation per clock and drives y toward zero
// in circular, linear or hyperbolic mode, with a valid/ready handshake on each side and one op in flight.
module cordic_vector_iter #(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 16,
    parameter int ITERATIONS = 16,
    parameter int GUARD      = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] angle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rotated_x,
    output logic [WIDTH-1:0] rotated_y,
    output logic [WIDTH-1:0] final_angle,
    output logic             err
);
    localparam int DW = WIDTH + GUARD;
    localparam int SW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(ITERATIONS - 1);
    localparam real ONE_R = 2.0 ** real'(FRAC);
    localparam logic signed [DW-1:0] PI_Q = DW'(longint'(3.141592653589793 * ONE_R));
    localparam logic signed [DW-1:0] SAT_MAX = {{(GUARD + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {{(GUARD + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {M_CIRC = 2'b00, M_LIN = 2'b01, M_HYP = 2'b10, M_ILLEGAL = 2'b11} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    // Hyperbolic shift for a given step: 1,2,3,4,4,5,...,13,13,14,... (4, 13, 40 repeat once).
    function automatic int hyp_shift(input int step);
        int s   = 1;
        int rep = 4;
        bit repeated = 1'b0;
        for (int i = 0; i < step; i++) begin
            if (s == rep && !repeated) begin
                repeated = 1'b1;
            end else begin
                if (s == rep) begin
                    rep      = 3 * rep + 1;
                    repeated = 1'b0;
                end
                s++;
            end
        end
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic signed [DW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    logic signed [DW-1:0] circ_dz [ITERATIONS];
    logic signed [DW-1:0] lin_dz  [ITERATIONS];
    logic signed [DW-1:0] hyp_dz  [ITERATIONS];
    logic [7:0]           hyp_sh  [ITERATIONS];

    for (genvar i = 0; i < ITERATIONS; i++) begin : g_tab
        localparam int  HS     = hyp_shift(i);
        localparam real HV     = 1.0 / (2.0 ** real'(HS));
        localparam real CIRC_R = $atan(1.0 / (2.0 ** real'(i))) * ONE_R;
        localparam real HYP_R  = 0.5 * $ln((1.0 + HV) / (1.0 - HV)) * ONE_R;
        assign circ_dz[i] = DW'(longint'(CIRC_R));
        assign lin_dz[i]  = DW'(longint'(1) << (FRAC - i));
        assign hyp_dz[i]  = DW'(longint'(HYP_R));
        assign hyp_sh[i]  = 8'(HS);
    end

    state_t               state_q;
    mode_t                mode_q;
    logic [SW-1:0]        step_q;
    logic signed [DW-1:0] x_q, y_q, z_q;
    logic [WIDTH-1:0]     rx_q, ry_q, fa_q;
    logic                 in_ready_q, out_valid_q, err_q;

    logic signed [DW-1:0] x_in, y_in, a_in, x0_d, y0_d, z0_d;
    logic signed [DW-1:0] x_sh, y_sh, x_d, y_d, z_d;
    logic [7:0]           shift;
    logic                 same_sign;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        x_in = {{GUARD{x[WIDTH-1]}}, x};
        y_in = {{GUARD{y[WIDTH-1]}}, y};
        a_in = {{GUARD{angle[WIDTH-1]}}, angle};
        x0_d = x_in;
        y0_d = y_in;
        z0_d = a_in;
        // Circular mode folds the left half-plane onto the right by rotating through pi.
        if (mode == M_CIRC && x_in[DW-1]) begin
            x0_d = -x_in;
            y0_d = -y_in;
            z0_d = y_in[DW-1] ? a_in - PI_Q : a_in + PI_Q;
        end
    end

    always_comb begin
        shift     = (mode_q == M_HYP) ? hyp_sh[step_q] : 8'(step_q);
        x_sh      = x_q >>> shift;
        y_sh      = y_q >>> shift;
        same_sign = (x_q[DW-1] == y_q[DW-1]);
        x_d       = x_q;
        y_d       = same_sign ? y_q - x_sh : y_q + x_sh;
        z_d       = z_q;
        unique case (mode_q)
            M_CIRC: begin
                x_d = same_sign ? x_q + y_sh : x_q - y_sh;
                z_d = same_sign ? z_q + circ_dz[step_q] : z_q - circ_dz[step_q];
            end
            M_LIN: begin
                z_d = same_sign ? z_q + lin_dz[step_q] : z_q - lin_dz[step_q];
            end
            M_HYP: begin
                x_d = same_sign ? x_q - y_sh : x_q + y_sh;
                z_d = same_sign ? z_q + hyp_dz[step_q] : z_q - hyp_dz[step_q];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= M_CIRC;
            step_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            fa_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mode_q     <= mode_t'(mode);
                        x_q        <= x0_d;
                        y_q        <= y0_d;
                        z_q        <= z0_d;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ITER;
                        // An illegal op spends a single cycle in ITER before reporting.
                        step_q     <= (mode == M_ILLEGAL) ? LAST_STEP : '0;
                    end
                end
                S_ITER: begin
                    x_q    <= x_d;
                    y_q    <= y_d;
                    z_q    <= z_d;
                    step_q <= step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        if (mode_q == M_ILLEGAL) begin
                            rx_q  <= sat(x_q);
                            ry_q  <= sat(y_q);
                            fa_q  <= sat(z_q);
                            err_q <= 1'b1;
                        end else begin
                            rx_q <= sat(x_d);
                            ry_q <= sat(y_d);
                            fa_q <= sat(z_d);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign err         = err_q;
    assign rotated_x   = rx_q;
    assign rotated_y   = ry_q;
    assign final_angle = fa_q;
endmodule

// File: tb/tb_cordic_vector_iter.sv
// Self-checking bench for cordic_vector_iter. It combines directed vectors, handshake corner sequences
// and random operands checked against real-valued atan2/sqrt/atanh expectations.
module tb_cordic_vector_iter;
    localparam int  WIDTH      = 32;
    localparam int  FRAC       = 16;
    localparam int  ITERATIONS = 16;
    localparam int  GUARD      = 2;
    localparam real SCALE      = 65536.0;
    localparam real KC         = 1.646760258;
    localparam real KH         = 0.828159;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] x = '0, y = '0, angle = '0;
    logic             in_ready, out_valid, err;
    logic [WIDTH-1:0] rotated_x, rotated_y, final_angle;

    int errors = 0;
    int checks = 0;

    cordic_vector_iter #(
        .WIDTH(WIDTH), .FRAC(FRAC), .ITERATIONS(ITERATIONS), .GUARD(GUARD)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .x(x), .y(y), .angle(angle),
        .out_valid(out_valid), .out_ready(out_ready),
        .rotated_x(rotated_x), .rotated_y(rotated_y), .final_angle(final_angle),
        .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] x, y, angle;
        longint      rx, rx_tol, ry, ry_tol, z, z_tol;
        logic        err;
        int          lat;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input longint got, input longint exp, input longint tol);
        checks++;
        if (got > exp + tol || got < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, got, exp, tol);
        end
    endtask

    function automatic longint rnd(input longint lo, input longint hi);
        return lo + longint'($urandom_range(32'(hi - lo)));
    endfunction

    function automatic longint rnd_mag();
        longint m = rnd(65536, 1048576);
        return ($urandom_range(1) == 1) ? m : -m;
    endfunction

    // Issue one operation, measure cycles from accept to out_valid, then consume the result.
    task automatic run_op(input logic [1:0] m, input logic [31:0] xi, input logic [31:0] yi,
                          input logic [31:0] ai, output longint rx, output longint ry,
                          output longint z, output logic e, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        mode = m; x = xi; y = yi; angle = ai; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
        rx = $signed(rotated_x);
        ry = $signed(rotated_y);
        z  = $signed(final_angle);
        e  = err;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t   vecs[8];
        longint rx, ry, z, cap_rx, cap_ry, cap_z;
        logic   e;
        int     lat, n, spurious;

        vecs[0] = '{2'b00, 32'h0003_0000, 32'h0004_0000, 32'h0, 539607, 8, 0, 24, 60771, 8, 1'b0, 16};
        vecs[1] = '{2'b00, 32'hFFFF_0000, 32'h0001_0000, 32'h0, 152624, 8, 0, 16, 154415, 8, 1'b0, 16};
        vecs[2] = '{2'b01, 32'h0002_0000, 32'h0001_0000, 32'h0, 131072, 0, 0, 8, 32768, 8, 1'b0, 16};
        vecs[3] = '{2'b10, 32'h0001_0000, 32'h0000_8000, 32'h0, 47003, 16, 0, 8, 35999, 8, 1'b0, 16};
        vecs[4] = '{2'b11, 32'h0000_0005, 32'h0000_0007, 32'h3, 5, 0, 7, 0, 3, 0, 1'b1, 1};
        vecs[5] = '{2'b01, 32'h0001_0000, 32'h0000_4000, 32'h0, 65536, 0, 0, 8, 16384, 8, 1'b0, 16};
        vecs[6] = '{2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 2147483647, 0, 0, 200000, 51472, 8, 1'b0, 16};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h0000_0000, 32'h0, 2147483647, 0, 0, 200000, 205887, 8, 1'b0, 16};

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_in_ready", in_ready, 1, 0);
        check("reset_out_valid", out_valid, 0, 0);
        check("reset_err", err, 0, 0);
        check("reset_rotated_x", rotated_x, 0, 0);
        check("reset_rotated_y", rotated_y, 0, 0);
        check("reset_final_angle", final_angle, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].mode, vecs[i].x, vecs[i].y, vecs[i].angle, rx, ry, z, e, lat);
            check($sformatf("vec%0d_rotated_x", i), rx, vecs[i].rx, vecs[i].rx_tol);
            check($sformatf("vec%0d_rotated_y", i), ry, vecs[i].ry, vecs[i].ry_tol);
            check($sformatf("vec%0d_final_angle", i), z, vecs[i].z, vecs[i].z_tol);
            check($sformatf("vec%0d_err", i), e, vecs[i].err, 0);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat, 0);
        end

        // err survives consumption and clears only when the next op is accepted.
        run_op(2'b11, 32'h11, 32'h22, 32'h0, rx, ry, z, e, lat);
        check("illegal_err", e, 1, 0);
        check("err_held_in_idle", err, 1, 0);
        mode = 2'b01; x = 32'h0001_0000; y = 32'h0; angle = 32'h0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("err_clears_on_accept", err, 0, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("err_seq_latency", n, 16, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure: hold the result for five cycles while in_valid is pulsed.
        mode = 2'b00; x = 32'h0003_0000; y = 32'h0004_0000; angle = 32'h0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp_latency", n, 16, 0);
        cap_rx = $signed(rotated_x);
        cap_ry = $signed(rotated_y);
        cap_z  = $signed(final_angle);
        check("bp_rotated_x", cap_rx, 539607, 8);
        for (int c = 0; c < 5; c++) begin
            mode = 2'b01; x = 32'(c + 1) << 16; y = 32'h0000_8000; in_valid = (c % 2 == 0);
            tick();
            check($sformatf("bp%0d_rotated_x", c), $signed(rotated_x), cap_rx, 0);
            check($sformatf("bp%0d_rotated_y", c), $signed(rotated_y), cap_ry, 0);
            check($sformatf("bp%0d_final_angle", c), $signed(final_angle), cap_z, 0);
            check($sformatf("bp%0d_out_valid", c), out_valid, 1, 0);
            check($sformatf("bp%0d_in_ready", c), in_ready, 0, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_consumed_out_valid", out_valid, 0, 0);
        check("bp_consumed_in_ready", in_ready, 1, 0);
        check("bp_hold_after_consume", $signed(rotated_x), cap_rx, 0);
        tick();
        check("bp_pulses_ignored", in_ready, 1, 0);

        // Random operands against real-valued expectations.
        for (int i = 0; i < 60; i++) begin
            longint xv, yv, av, exp_rx, exp_z, r;
            real    xr, yr;
            logic [1:0] m = 2'(i % 3);
            av = 0;
            if (m == 2'b00) begin
                xv = rnd_mag();
                yv = rnd(-1048576, 1048576);
                av = rnd(-65536, 65536);
            end else if (m == 2'b01) begin
                xv = rnd_mag();
                r  = rnd(-1900, 1900);
                yv = (xv * r) / 1000;
            end else begin
                xv = rnd(65536, 1048576);
                r  = rnd(-780, 780);
                yv = (xv * r) / 1000;
            end
            xr = real'(xv);
            yr = real'(yv);
            run_op(m, 32'(xv), 32'(yv), 32'(av), rx, ry, z, e, lat);
            if (m == 2'b00) begin
                exp_rx = longint'(KC * $sqrt(xr * xr + yr * yr));
                exp_z  = av + longint'($atan2(yr, xr) * SCALE);
                check($sformatf("rnd%0d_circ_x", i), rx, exp_rx, 32);
                check($sformatf("rnd%0d_circ_y", i), ry, 0, exp_rx / 8192 + 8);
                check($sformatf("rnd%0d_circ_z", i), z, exp_z, 12);
            end else if (m == 2'b01) begin
                exp_z = longint'(yr / xr * SCALE);
                check($sformatf("rnd%0d_lin_x", i), rx, xv, 0);
                check($sformatf("rnd%0d_lin_y", i), ry, 0, (xv < 0 ? -xv : xv) / 8192 + 8);
                check($sformatf("rnd%0d_lin_z", i), z, exp_z, 8);
            end else begin
                exp_rx = longint'(KH * $sqrt(xr * xr - yr * yr));
                exp_z  = longint'(0.5 * $ln((xr + yr) / (xr - yr)) * SCALE);
                check($sformatf("rnd%0d_hyp_x", i), rx, exp_rx, 32);
                check($sformatf("rnd%0d_hyp_y", i), ry, 0, exp_rx / 4096 + 8);
                check($sformatf("rnd%0d_hyp_z", i), z, exp_z, 16);
            end
            check($sformatf("rnd%0d_err", i), e, 0, 0);
            check($sformatf("rnd%0d_latency", i), lat, 16, 0);
        end

        // Reset in the middle of an operation discards it without a result pulse.
        mode = 2'b00; x = 32'h0003_0000; y = 32'h0004_0000; angle = 32'h0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("midrst_out_valid", out_valid, 0, 0);
        check("midrst_in_ready", in_ready, 1, 0);
        check("midrst_err", err, 0, 0);
        check("midrst_rotated_x", rotated_x, 0, 0);
        check("midrst_rotated_y", rotated_y, 0, 0);
        check("midrst_final_angle", final_angle, 0, 0);
        reset = 1'b0;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (out_valid) spurious++;
        end
        check("midrst_no_spurious", spurious, 0, 0);
        check("midrst_idle_after", in_ready, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
